// File: rtl/gemm_pkg.sv
// gemm_pkg: shared widths, tile geometry and FSM state encoding for the GEMM engine
package gemm_pkg;
  localparam int InDataWidth = 8;
  localparam int RowPar = 4;
  localparam int ColPar = 16;
  localparam int InDataWidth_a = RowPar * InDataWidth;
  localparam int InDataWidth_b = ColPar * InDataWidth;
  localparam int OutDataWidth = 32;
  localparam int AddrWidth = 12;
  localparam int SizeAddrWidth = 32;
  localparam int TileSize = RowPar * ColPar;
  localparam int OutTileWidth = TileSize * OutDataWidth;
  typedef enum logic [2:0] {S_IDLE, S_COMPUTE, S_DRAIN, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/gemm_mac_array.sv
// gemm_mac_array: RowPar x ColPar signed int8 MAC lanes, packed MSB-first output
module gemm_mac_array
  import gemm_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic [InDataWidth_a-1:0] a_i,
  input  logic [InDataWidth_b-1:0] b_i,
  output logic [OutTileWidth-1:0]  acc_o
);
  for (genvar q = 0; q < RowPar; q++) begin : g_row
    for (genvar l = 0; l < ColPar; l++) begin : g_col
      logic signed [2*InDataWidth-1:0] p;
      logic [OutDataWidth-1:0] acc;
      assign p = $signed(a_i[q*InDataWidth +: InDataWidth]) * $signed(b_i[l*InDataWidth +: InDataWidth]);
      assign acc_o[(TileSize-1-(q*ColPar+l))*OutDataWidth +: OutDataWidth] = acc;
      always_ff @(posedge clk_i) begin
        if (rst_i) acc <= '0;
        else if (en_i) acc <= (clr_i ? '0 : acc) + OutDataWidth'(p);
      end
    end
  end
endmodule

// File: rtl/single_port_memory.sv
// single_port_memory: synchronous-write, registered-read single-port SRAM model
module single_port_memory #(
  parameter int DataWidth = 32,
  parameter int DataDepth = 4096,
  parameter int AddrWidth = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  output logic [DataWidth-1:0] rd_data_o
);
  logic [DataWidth-1:0] memory [DataDepth];
  always_ff @(posedge clk_i) begin
    if (we_i) memory[addr_i] <= wr_data_i;
    rd_data_o <= rst_i ? '0 : memory[addr_i];
  end
endmodule

// File: rtl/gemm_accelerator_top.sv
// gemm_accelerator_top: tiled int8 GEMM sequencer streaming A/B SRAM words into a MAC array
module gemm_accelerator_top
  import gemm_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  input  logic [InDataWidth_a-1:0] sram_a_rdata_i,
  input  logic [InDataWidth_b-1:0] sram_b_rdata_i,
  output logic [OutTileWidth-1:0]  sram_c_wdata_o,
  output logic                     sram_c_we_o,
  output logic                     done_o
);
  state_t state;
  logic [SizeAddrWidth-1:0] k_sz, m_t, n_t, tm, tn, kc;
  logic [AddrWidth-1:0] a_base, b_base, t;
  logic v, first;
  assign sram_a_addr_o = a_base + kc[AddrWidth-1:0];
  assign sram_b_addr_o = b_base + kc[AddrWidth-1:0];
  assign sram_c_addr_o = t;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      {k_sz, m_t, n_t, tm, tn, kc} <= '0;
      {a_base, b_base, t} <= '0;
      {v, first, sram_c_we_o, done_o} <= '0;
    end else begin
      v <= state == S_COMPUTE;
      first <= state == S_COMPUTE && kc == '0;
      sram_c_we_o <= state == S_DRAIN;
      done_o <= state == S_DONE;
      case (state)
        S_IDLE: if (start_i) begin
          k_sz <= K_size_i;
          m_t <= M_size_i / RowPar;
          n_t <= N_size_i / ColPar;
          {tm, tn, kc} <= '0;
          {a_base, b_base, t} <= '0;
          state <= (M_size_i / RowPar == 0 || K_size_i == 0 || N_size_i / ColPar == 0) ? S_DONE : S_COMPUTE;
        end
        S_COMPUTE: begin
          kc <= kc + 1;
          if (kc == k_sz - 1) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_WRITE;
        S_WRITE: begin
          t <= t + 1'b1;
          kc <= '0;
          state <= S_COMPUTE;
          if (tn == n_t - 1) begin
            tn <= '0;
            b_base <= '0;
            if (tm == m_t - 1) state <= S_DONE;
            else begin
              tm <= tm + 1;
              a_base <= a_base + k_sz[AddrWidth-1:0];
            end
          end else begin
            tn <= tn + 1;
            b_base <= b_base + k_sz[AddrWidth-1:0];
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  gemm_mac_array u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (first),
    .en_i  (v),
    .a_i   (sram_a_rdata_i),
    .b_i   (sram_b_rdata_i),
    .acc_o (sram_c_wdata_o)
  );
endmodule

// File: tb/tb_gemm_accelerator_top.sv
// tb_gemm_accelerator_top: scoreboard bench for the tiled GEMM engine with behavioural SRAMs
module tb_gemm_accelerator_top;
  import gemm_pkg::*;
  typedef struct {
    logic [AddrWidth-1:0]    addr;
    logic [OutTileWidth-1:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst, start;
  logic [SizeAddrWidth-1:0] m_sz, k_sz, n_sz;
  logic [AddrWidth-1:0] a_addr, b_addr, c_addr, ld_addr;
  logic [InDataWidth_a-1:0] a_rdata, ld_a_data;
  logic [InDataWidth_b-1:0] b_rdata, ld_b_data;
  logic [OutTileWidth-1:0] c_wdata, c_rdata;
  logic c_we, done, ld, ld_a_we, ld_b_we;
  exp_t exp_q[$];
  exp_t e;
  int vec = 0, miss = 0, we_cnt = 0, fi;
  byte a_m[32][64];
  byte b_m[64][32];
  always #5 clk = ~clk;
  gemm_accelerator_top dut (
    .clk_i (clk), .rst_i (rst), .start_i (start),
    .M_size_i (m_sz), .K_size_i (k_sz), .N_size_i (n_sz),
    .sram_a_addr_o (a_addr), .sram_b_addr_o (b_addr), .sram_c_addr_o (c_addr),
    .sram_a_rdata_i (a_rdata), .sram_b_rdata_i (b_rdata),
    .sram_c_wdata_o (c_wdata), .sram_c_we_o (c_we), .done_o (done)
  );
  single_port_memory #(.DataWidth(InDataWidth_a), .DataDepth(4096), .AddrWidth(AddrWidth)) a_mem (
    .clk_i (clk), .rst_i (rst), .we_i (ld_a_we), .addr_i (ld ? ld_addr : a_addr),
    .wr_data_i (ld_a_data), .rd_data_o (a_rdata)
  );
  single_port_memory #(.DataWidth(InDataWidth_b), .DataDepth(4096), .AddrWidth(AddrWidth)) b_mem (
    .clk_i (clk), .rst_i (rst), .we_i (ld_b_we), .addr_i (ld ? ld_addr : b_addr),
    .wr_data_i (ld_b_data), .rd_data_o (b_rdata)
  );
  single_port_memory #(.DataWidth(OutTileWidth), .DataDepth(4096), .AddrWidth(AddrWidth)) c_mem (
    .clk_i (clk), .rst_i (rst), .we_i (c_we), .addr_i (c_addr),
    .wr_data_i (c_wdata), .rd_data_o (c_rdata)
  );
  always @(negedge clk) begin
    if (!rst && c_we) begin
      we_cnt++;
      vec++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL c_write unexpected write at addr %0d (no tile outstanding)", c_addr);
      end else begin
        e = exp_q.pop_front();
        fi = -1;
        for (int i = TileSize - 1; i >= 0; i--)
          if (c_wdata[i*OutDataWidth +: OutDataWidth] !== e.data[i*OutDataWidth +: OutDataWidth]) fi = i;
        if (c_addr !== e.addr || fi >= 0) begin
          miss++;
          $display("FAIL c_write addr got %0d want %0d; word slot %0d got %h want %h", c_addr, e.addr, fi,
                   fi >= 0 ? c_wdata[fi*OutDataWidth +: OutDataWidth] : 32'h0,
                   fi >= 0 ? e.data[fi*OutDataWidth +: OutDataWidth] : 32'h0);
        end
      end
    end
  end
  task automatic fill_rand();
    for (int i = 0; i < 32; i++) for (int j = 0; j < 64; j++) a_m[i][j] = byte'($urandom);
    for (int i = 0; i < 64; i++) for (int j = 0; j < 32; j++) b_m[i][j] = byte'($urandom);
  endtask
  task automatic fill_const(input byte av, input byte bv);
    for (int i = 0; i < 32; i++) for (int j = 0; j < 64; j++) a_m[i][j] = av;
    for (int i = 0; i < 64; i++) for (int j = 0; j < 32; j++) b_m[i][j] = bv;
  endtask
  task automatic load(input int m, input int k, input int n);
    ld = 1'b1;
    for (int tm = 0; tm < m / RowPar; tm++)
      for (int kk = 0; kk < k; kk++) begin
        @(negedge clk);
        ld_addr = AddrWidth'(tm * k + kk);
        for (int q = 0; q < RowPar; q++) ld_a_data[q*8 +: 8] = a_m[tm*RowPar+q][kk];
        ld_a_we = 1'b1;
      end
    @(negedge clk);
    ld_a_we = 1'b0;
    for (int tn = 0; tn < n / ColPar; tn++)
      for (int kk = 0; kk < k; kk++) begin
        @(negedge clk);
        ld_addr = AddrWidth'(tn * k + kk);
        for (int l = 0; l < ColPar; l++) ld_b_data[l*8 +: 8] = b_m[kk][tn*ColPar+l];
        ld_b_we = 1'b1;
      end
    @(negedge clk);
    ld_b_we = 1'b0;
    ld = 1'b0;
  endtask
  task automatic push_golden(input int m, input int k, input int n);
    exp_t x;
    int s;
    if (k == 0) return;
    for (int tm = 0; tm < m / RowPar; tm++)
      for (int tn = 0; tn < n / ColPar; tn++) begin
        x.addr = AddrWidth'(tm * (n / ColPar) + tn);
        x.data = '0;
        for (int q = 0; q < RowPar; q++)
          for (int l = 0; l < ColPar; l++) begin
            s = 0;
            for (int kk = 0; kk < k; kk++) s += int'(a_m[tm*RowPar+q][kk]) * int'(b_m[kk][tn*ColPar+l]);
            x.data[(TileSize-1-(q*ColPar+l))*OutDataWidth +: OutDataWidth] = s;
          end
        exp_q.push_back(x);
      end
  endtask
  task automatic pulse_start(input int m, input int k, input int n);
    @(negedge clk);
    m_sz = m;
    k_sz = k;
    n_sz = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vec++;
    if (done !== 1'b0) begin
      miss++;
      $display("FAIL done_after_start got %b want 0", done);
    end
  endtask
  task automatic run(input int m, input int k, input int n, input bit busy, output int cyc);
    int dn, tiles;
    tiles = (k == 0) ? 0 : (m / RowPar) * (n / ColPar);
    load(m, k, n);
    push_golden(m, k, n);
    we_cnt = 0;
    dn = 0;
    pulse_start(m, k, n);
    cyc = 1;
    while (dn == 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (done) dn++;
      start = busy && dn == 0 && (cyc % 9 == 4);
    end
    start = 1'b0;
    vec++;
    if (dn == 0) begin
      miss++;
      $display("FAIL done_timeout after %0d cycles", cyc);
    end
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    vec++;
    if (dn != 1) begin
      miss++;
      $display("FAIL done_pulses got %0d want 1", dn);
    end
    vec++;
    if (we_cnt != tiles) begin
      miss++;
      $display("FAIL we_pulses got %0d want %0d", we_cnt, tiles);
    end
    vec++;
    if (exp_q.size() != 0) begin
      miss++;
      $display("FAIL tiles_outstanding got %0d want 0", exp_q.size());
    end
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    vec += 4;
    if (c_we !== 1'b0) begin miss++; $display("FAIL reset_we got %b want 0", c_we); end
    if (done !== 1'b0) begin miss++; $display("FAIL reset_done got %b want 0", done); end
    if (a_addr !== '0 || b_addr !== '0) begin miss++; $display("FAIL reset_ab_addr got %0d/%0d want 0/0", a_addr, b_addr); end
    if (c_addr !== '0) begin miss++; $display("FAIL reset_c_addr got %0d want 0", c_addr); end
  endtask
  task automatic test_random();
    int cyc;
    fill_rand();
    run(32, 32, 32, 1'b0, cyc);
    vec++;
    if (cyc != 16 * 34 + 2) begin miss++; $display("FAIL random_latency got %0d want %0d", cyc, 16 * 34 + 2); end
  endtask
  task automatic test_back_to_back();
    int cyc;
    run(4, 64, 16, 1'b0, cyc);
    vec++;
    if (cyc != 66 + 2) begin miss++; $display("FAIL b2b_latency got %0d want 68", cyc); end
  endtask
  task automatic test_extremes();
    int cyc;
    fill_const(-8'sd128, -8'sd128);
    run(4, 64, 16, 1'b0, cyc);
    vec += 2;
    if (c_mem.memory[0][OutTileWidth-1 -: 32] !== 32'd1048576) begin
      miss++; $display("FAIL min_x_min_first got %0d want 1048576", $signed(c_mem.memory[0][OutTileWidth-1 -: 32]));
    end
    if (c_mem.memory[0][31:0] !== 32'd1048576) begin
      miss++; $display("FAIL min_x_min_last got %0d want 1048576", $signed(c_mem.memory[0][31:0]));
    end
    fill_const(8'sd127, -8'sd128);
    run(4, 1, 16, 1'b0, cyc);
    vec++;
    if (c_mem.memory[0][OutTileWidth-1 -: 32] !== 32'hFFFF_C080) begin
      miss++; $display("FAIL k1_max_x_min got %0d want -16256", $signed(c_mem.memory[0][OutTileWidth-1 -: 32]));
    end
  endtask
  task automatic test_reset_midrun();
    int cyc;
    fill_rand();
    load(32, 32, 32);
    push_golden(32, 32, 32);
    pulse_start(32, 32, 32);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vec += 2;
    if (c_we !== 1'b0) begin miss++; $display("FAIL midrun_reset_we got %b want 0", c_we); end
    if (done !== 1'b0) begin miss++; $display("FAIL midrun_reset_done got %b want 0", done); end
    exp_q.delete();
    we_cnt = 0;
    repeat (3) @(negedge clk);
    vec++;
    if (we_cnt != 0) begin miss++; $display("FAIL midrun_reset_writes got %0d want 0", we_cnt); end
    rst = 1'b0;
    run(32, 32, 32, 1'b0, cyc);
  endtask
  task automatic test_busy_start();
    int cyc;
    fill_rand();
    run(8, 16, 32, 1'b1, cyc);
  endtask
  task automatic test_zero_k();
    int cyc;
    run(4, 0, 16, 1'b0, cyc);
    vec++;
    if (cyc > 2) begin miss++; $display("FAIL zero_k_latency got %0d want <=2", cyc); end
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    {m_sz, k_sz, n_sz} = '0;
    {ld, ld_a_we, ld_b_we} = '0;
    ld_addr = '0;
    ld_a_data = '0;
    ld_b_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_random();
    test_back_to_back();
    test_extremes();
    test_reset_midrun();
    test_busy_start();
    test_zero_k();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/gemm_accelerator_top.md
Name: gemm_accelerator_top

Overview:
Tiled signed-int8 GEMM engine computing C[M×N] = A[M×K]·B[K×N] into 32-bit accumulators, with runtime M, K, N. Output is produced as RowPar×ColPar tiles. The block reads packed A-column and B-row words from two external single-port SRAMs and writes one packed tile word per output tile to a third SRAM. The SRAMs are single_port_memory instances: registered read with 1-cycle latency, synchronous write.

Parameters:
InDataWidth, 8, width of one signed operand element
RowPar, 4, tile rows (M direction)
ColPar, 16, tile columns (N direction)
InDataWidth_a, RowPar*InDataWidth (32), A SRAM word width
InDataWidth_b, ColPar*InDataWidth (128), B SRAM word width
OutDataWidth, 32, accumulator/result element width
AddrWidth, 12, SRAM address width (depth 4096)
SizeAddrWidth, 32, width of M/K/N size inputs

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
start_i  in  1  one-cycle start pulse, sampled in IDLE only
M_size_i  in  SizeAddrWidth  M, latched on accepted start
K_size_i  in  SizeAddrWidth  K, latched on accepted start
N_size_i  in  SizeAddrWidth  N, latched on accepted start
sram_a_addr_o  out  AddrWidth  A read address
sram_b_addr_o  out  AddrWidth  B read address
sram_c_addr_o  out  AddrWidth  C write address (tile index)
sram_a_rdata_i  in  InDataWidth_a  A data, valid 1 cycle after address
sram_b_rdata_i  in  InDataWidth_b  B data, valid 1 cycle after address
sram_c_wdata_o  out  RowPar*ColPar*OutDataWidth (2048)  packed tile
sram_c_we_o  out  1  C write enable
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: FSM to IDLE; accumulators, counters and all address outputs cleared to 0; sram_c_we_o=0; done_o=0. Reset mid-run aborts the run; no further C writes occur.
- Memory layout:
  - A: Mt=M/RowPar, Nt=N/ColPar; M must be a multiple of RowPar and N a multiple of ColPar. Padding lanes are zeroed in memory by software.
  - A word at address tm*K+k holds A[tm*RowPar+q][k] at bits [q*8+:8].
  - B word at address tn*K+k holds B[k][tn*ColPar+l] at bits [l*8+:8].
- Tile order: tm outer, tn inner. Tile index t = tm*Nt+tn is the C write address.
- C packing: element i = q*ColPar+l is placed at bits [(RowPar*ColPar-1-i)*32 +: 32]. C[0][0] occupies the MSBs.
- Arithmetic:
  - Each product is signed 8×8, sign-extended to 32 bits.
  - Accumulation is 32-bit two's-complement with wrap; no saturation.
- FSM:
  - IDLE: on start_i, latch sizes and set tm=tn=k=0. If any size is 0, go directly to DONE.
  - COMPUTE: drive the A and B addresses for k each cycle, k=0..K-1. A registered valid follows the address by one cycle. MAC on valid; accumulators are cleared at the first MAC of each tile. After issuing k=K-1, go to DRAIN.
  - DRAIN: perform the final MAC.
  - WRITE: sram_c_we_o=1 for exactly one cycle, sram_c_addr_o=t, wdata = accumulators. Then go to COMPUTE for the next tile, or to DONE after the last tile.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- Throughput: K+2 cycles per tile; total latency from start ≈ Mt*Nt*(K+2)+2 cycles.
- done_o must be 0 in the cycle after an accepted start.
- start_i outside IDLE is ignored. Back-to-back runs are supported with no reset between them.
- sram_c_we_o is 0 in every state except WRITE.
- single_port_memory:
  - Parameters DataWidth, DataDepth, AddrWidth.
  - Storage array named memory, backdoor-accessible.
  - Write on we at the clock edge; rd_data registered from memory[addr]; rd_data cleared on reset.

Decomposition:
- Package gemm_pkg holds the default widths, RowPar/ColPar, the FSM state enum, and a TileSize constant.
- One natural sub-module: gemm_mac_array. It holds RowPar×ColPar MAC lanes with clear/enable and packed output in MSB-first order.

Test Plan:
- M=K=N=32, random int8 -> 16 tiles written at C[0..15]; every element equals the golden dot product; done within ~16*34+2 cycles.
- M=4, K=64, N=16 run back-to-back after the first run without reset -> 1 tile at C[0]; done re-pulses exactly once.
- All A=-128, all B=-128, K=64, M=4, N=16 -> every element is 1048576; K=1 with A=127, B=-128 -> -16256.
- Assert rst_i mid-run in the K=32 case -> we and done drop immediately; a fresh start produces correct results.
- start_i pulses while busy -> ignored; exactly Mt*Nt we pulses and one done per run.
- K=0 -> done_o pulses within 2 cycles; no C writes.
